sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 63: max wait cycles for mem_ready before a transaction is abandoned.
REQ-002 clk_sys  in  1  system clock (57.272 MHz); all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 dl_req  in  1  download write request, level, held until dl_ack.
REQ-005 dl_addr  in  25  download byte address.
REQ-006 dl_data  in  8  download write byte.
REQ-007 dl_ack  out  1  one-cycle pulse: download request granted, addr/data captured.
REQ-008 cas_req  in  1  cassette read request, level, held until cas_ack.
REQ-009 cas_addr  in  25  cassette byte address.
REQ-010 cas_ack  out  1  one-cycle pulse: cassette request granted, addr captured.
REQ-011 cas_data  out  8  read byte, held until next cassette completion.
REQ-012 cas_valid  out  1  one-cycle pulse: cas_data updated.
REQ-013 mem_addr  out  25  SDRAM address; mem_din out 8 write data.
REQ-014 mem_we, mem_rd  out  1 each  single-cycle SDRAM command strobes.
REQ-015 mem_dout  in  8  SDRAM read data; mem_ready in 1 SDRAM command complete.
REQ-016 busy  out  1  high in any state except IDLE; tmo_err out 1 sticky timeout flag.

Function
REQ-017 States: IDLE, WR, RD, WAIT_WR, WAIT_RD; exactly one state active.
REQ-018 IDLE: dl_req or cas_req sampled high at edge N -> at edge N+1 the winner's ack pulses, mem_addr/mem_din registered, state moves to WR or RD.
REQ-019 Simultaneous requests resolved per REQ-031/032; the loser stays pending, no ack.
REQ-020 WR: mem_we high exactly one cycle, then WAIT_WR; RD: mem_rd high exactly one cycle, then WAIT_RD.
REQ-021 mem_we and mem_rd are never high in the same cycle.
REQ-022 WAIT_WR: mem_ready high -> IDLE next edge.
REQ-023 WAIT_RD: mem_ready high -> cas_data <= mem_dout and cas_valid pulses on next edge, state IDLE.
REQ-024 Wait counter 6+ bits, cleared on entering WAIT_*; count reaching TIMEOUT without mem_ready -> IDLE, tmo_err set; for reads cas_data <= 8'hFF with cas_valid pulse.
REQ-025 A new grant may occur on the edge after return to IDLE; min 3 cycles per transaction.
REQ-026 mem_ready outside WAIT_* ignored.
REQ-027 Requests dropped before ack are ignored; ack is never issued to an unasserted req.
REQ-028 mem_addr/mem_din hold last granted values between transactions.

Reset
REQ-029 reset asserted: state IDLE, dl_ack, cas_ack, cas_valid, mem_we, mem_rd, busy, tmo_err = 0, cas_data = 8'h00, mem_addr = 0, mem_din = 0, counter = 0, RR pointer = download — immediately, without waiting for clk_sys.
REQ-030 Reset mid-transaction aborts it; no ack or cas_valid pulse for the aborted request after reset release.

Configuration
REQ-031 Macro SDRAM_ARB_RR_EN defined: round-robin; on simultaneous requests the port not granted last wins; pointer updates on every grant.
REQ-032 Macro undefined: fixed priority, download always wins simultaneous requests; no pointer register.

Verification
REQ-033 dl_req=1, dl_addr=25'h00010, dl_data=8'hA5, mem_ready one cycle after mem_we -> dl_ack at N+1, mem_we one cycle with mem_addr=25'h10/mem_din=8'hA5, busy low after 3 cycles.
REQ-034 cas_req, cas_addr=25'h00200, mem_dout=8'h3C with mem_ready 4 cycles after mem_rd -> cas_valid one pulse, cas_data=8'h3C, held after.
REQ-035 Both req held high 4 transactions: RR_EN grants dl,cas,dl,cas; without it dl,dl,dl,dl.
REQ-036 cas read, mem_ready never asserted -> after TIMEOUT=63 cycles cas_valid pulses, cas_data=8'hFF, tmo_err=1, next request still served.
REQ-037 reset asserted between clk_sys edges during WAIT_RD -> mem_rd/busy/cas_valid 0 immediately; no cas_valid after release even if mem_ready pulses.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Two-port SDRAM arbiter: download writes and cassette reads share one port.
// Define SDRAM_ARB_RR_EN for round-robin arbitration (fixed download priority otherwise).
module sdram_arbiter #(
  parameter int TIMEOUT = 63
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dl_req,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_ack,
  input  logic        cas_req,
  input  logic [24:0] cas_addr,
  output logic        cas_ack,
  output logic [7:0]  cas_data,
  output logic        cas_valid,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic [7:0]  mem_dout,
  input  logic        mem_ready,
  output logic        busy,
  output logic        tmo_err
);

  localparam int CW = (TIMEOUT < 64) ? 6 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD      = 3'd2;
  localparam logic [2:0] S_WAIT_WR = 3'd3;
  localparam logic [2:0] S_WAIT_RD = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          idle;
  logic          grant_dl;
  logic          grant_cas;

  assign idle = (state == S_IDLE);

`ifdef SDRAM_ARB_RR_EN
  logic prefer_cas;

  // Pointer favours the port that was not granted last
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      prefer_cas <= 1'b0;
    else if (grant_dl || grant_cas)
      prefer_cas <= grant_dl;
  end

  assign grant_dl = idle && dl_req && !(cas_req && prefer_cas);
`else
  assign grant_dl = idle && dl_req;
`endif

  assign grant_cas = idle && cas_req && !grant_dl;

  assign mem_we = (state == S_WR);
  assign mem_rd = (state == S_RD);
  assign busy   = !idle;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dl_ack    <= 1'b0;
      cas_ack   <= 1'b0;
      cas_valid <= 1'b0;
      cas_data  <= 8'h00;
      mem_addr  <= 25'd0;
      mem_din   <= 8'h00;
      tmo_err   <= 1'b0;
    end else begin
      dl_ack    <= grant_dl;
      cas_ack   <= grant_cas;
      cas_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (grant_dl) begin
            mem_addr <= dl_addr;
            mem_din  <= dl_data;
            state    <= S_WR;
          end else if (grant_cas) begin
            mem_addr <= cas_addr;
            state    <= S_RD;
          end
        end
        S_WR: begin
          cnt   <= '0;
          state <= S_WAIT_WR;
        end
        S_RD: begin
          cnt   <= '0;
          state <= S_WAIT_RD;
        end
        S_WAIT_WR, S_WAIT_RD: begin
          if (mem_ready) begin
            state <= S_IDLE;
            if (state == S_WAIT_RD) begin
              cas_data  <= mem_dout;
              cas_valid <= 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            // Abandon; a read still completes with a marker byte
            state   <= S_IDLE;
            tmo_err <= 1'b1;
            if (state == S_WAIT_RD) begin
              cas_data  <= 8'hFF;
              cas_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter.
// Cycle-level reference model with randomized requesters and SDRAM latency.
module tb_sdram_arbiter;

  localparam int TIMEOUT = 63;
`ifdef SDRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic        dl_req = 1'b0;
  logic [24:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        dl_ack;
  logic        cas_req = 1'b0;
  logic [24:0] cas_addr = '0;
  logic        cas_ack;
  logic [7:0]  cas_data;
  logic        cas_valid;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        mem_rd;
  logic [7:0]  mem_dout = '0;
  logic        mem_ready = 1'b0;
  logic        busy;
  logic        tmo_err;

  sdram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dl_req(dl_req), .dl_addr(dl_addr),
    .dl_data(dl_data), .dl_ack(dl_ack),
    .cas_req(cas_req), .cas_addr(cas_addr),
    .cas_ack(cas_ack), .cas_data(cas_data),
    .cas_valid(cas_valid), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_we(mem_we),
    .mem_rd(mem_rd), .mem_dout(mem_dout),
    .mem_ready(mem_ready), .busy(busy),
    .tmo_err(tmo_err)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit [7:0]  mem [bit [24:0]];
  bit        last_dl;
  bit        act, act_rd, act_never;
  int        done_cnt, ready_cnt;
  bit [7:0]  rd_val, cas_exp;
  bit        tmo_exp;
  bit [24:0] addr_exp;
  bit [7:0]  din_exp;
  int        mode;
  int        lat_fix;
  bit        gseq[$];
  int        obs_dl, obs_val;

  function automatic int pick_lat();
    if (lat_fix >= 0) return lat_fix;
    case ($urandom_range(0, 11))
      0: return 999;
      1: return TIMEOUT;
      2: return TIMEOUT + 1;
      default: return $urandom_range(1, 6);
    endcase
  endfunction

  task automatic model_reset();
    act = 0; act_rd = 0; act_never = 0;
    tmo_exp = 0; cas_exp = 8'h00;
    addr_exp = '0; din_exp = '0;
    last_dl = 0;
    dl_req = 0; cas_req = 0;
    mem_ready = 0;
  endtask

  task automatic do_reset();
    @(posedge clk_sys); #3;
    reset = 1'b1;
    model_reset();
    @(posedge clk_sys); #3;
    reset = 1'b0;
  endtask

  task automatic cycle();
    bit pdl, pcas, pbusy, gdl, gcas, done;
    bit [24:0] pdla, pcasa;
    bit [7:0]  pdld;
    int L;
    pdl = dl_req; pcas = cas_req; pbusy = act;
    pdla = dl_addr; pcasa = cas_addr; pdld = dl_data;
    @(posedge clk_sys); #1;
    gdl  = !pbusy && pdl && !(RR && pcas && last_dl);
    gcas = !pbusy && pcas && !gdl;
    if (dl_ack) obs_dl++;
    if (cas_valid) obs_val++;
    checks++;
    if (dl_ack !== gdl || cas_ack !== gcas) begin
      failures++;
      $display("FAIL ack: dl_ack=%b cas_ack=%b want %b %b",
               dl_ack, cas_ack, gdl, gcas);
    end
    done = 0;
    if (act) begin
      done_cnt--;
      if (done_cnt == 0) begin
        done = 1; act = 0;
        if (act_never) tmo_exp = 1;
        if (act_rd) cas_exp = act_never ? 8'hFF : rd_val;
      end
    end
    if (gdl) begin
      last_dl = 1; addr_exp = pdla; din_exp = pdld;
      mem[pdla] = pdld;
    end
    if (gcas) begin
      last_dl = 0; addr_exp = pcasa;
    end
    if (gdl || gcas) begin
      L = pick_lat();
      act = 1; act_rd = gcas;
      act_never = (L > TIMEOUT);
      done_cnt = act_never ? TIMEOUT + 1 : L + 1;
      ready_cnt = L;
      gseq.push_back(gcas);
      if (gcas) begin
        rd_val = mem.exists(pcasa) ? mem[pcasa] : 8'($urandom);
        mem[pcasa] = rd_val;
      end
    end
    checks++;
    if (mem_we !== gdl || mem_rd !== gcas) begin
      failures++;
      $display("FAIL strobe: we=%b rd=%b want %b %b",
               mem_we, mem_rd, gdl, gcas);
    end
    checks++;
    if (mem_addr !== addr_exp || mem_din !== din_exp) begin
      failures++;
      $display("FAIL mem_bus: addr=%h din=%h want %h %h",
               mem_addr, mem_din, addr_exp, din_exp);
    end
    checks++;
    if (busy !== act) begin
      failures++;
      $display("FAIL busy: got %b want %b", busy, act);
    end
    checks++;
    if (cas_valid !== (done && act_rd) || cas_data !== cas_exp) begin
      failures++;
      $display("FAIL cas_out: valid=%b data=%h want %b %h",
               cas_valid, cas_data, done && act_rd, cas_exp);
    end
    checks++;
    if (tmo_err !== tmo_exp) begin
      failures++;
      $display("FAIL tmo_err: got %b want %b", tmo_err, tmo_exp);
    end
    // SDRAM responder
    if (act && !(gdl || gcas)) ready_cnt--;
    if (act && !act_never && ready_cnt == 0) begin
      mem_ready = 1;
      mem_dout = act_rd ? rd_val : 8'($urandom);
    end else if (act && !(gdl || gcas)) begin
      mem_ready = 0;
      mem_dout = 8'($urandom);
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_dout = 8'($urandom);
    end
    // Requesters
    if (gdl && mode != 1) dl_req = 0;
    if (gcas && mode != 1) cas_req = 0;
    if (mode == 2) begin
      if (!dl_req && $urandom_range(0, 2) == 0) begin
        dl_req = 1;
        dl_addr = 25'($urandom_range(0, 15));
        dl_data = 8'($urandom);
      end else if (dl_req && $urandom_range(0, 24) == 0) begin
        dl_req = 0;
      end
      if (!cas_req && $urandom_range(0, 2) == 0) begin
        cas_req = 1;
        cas_addr = 25'($urandom_range(0, 15));
      end else if (cas_req && $urandom_range(0, 24) == 0) begin
        cas_req = 0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    model_reset();
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({busy, mem_we, mem_rd, dl_ack, cas_ack, cas_valid, tmo_err}
        !== 7'b0 || cas_data !== 8'h00 || mem_addr !== 25'd0
        || mem_din !== 8'h00) begin
      failures++;
      $display("FAIL reset_async: busy=%b we=%b rd=%b cd=%h ma=%h",
               busy, mem_we, mem_rd, cas_data, mem_addr);
    end
    @(posedge clk_sys); #3;
    reset = 1'b0;
    mode = 0; lat_fix = 1;
    run(3);
  endtask

  task automatic test_write();
    int d0;
    d0 = obs_dl;
    mode = 0; lat_fix = 1;
    dl_addr = 25'h00010; dl_data = 8'hA5; dl_req = 1;
    run(5);
    checks++;
    if (obs_dl - d0 !== 1 || mem_din !== 8'hA5
        || mem_addr !== 25'h10) begin
      failures++;
      $display("FAIL write: acks=%0d din=%h addr=%h want 1 a5 10",
               obs_dl - d0, mem_din, mem_addr);
    end
  endtask

  task automatic test_read();
    int v0;
    v0 = obs_val;
    mem[25'h200] = 8'h3C;
    mode = 0; lat_fix = 4;
    cas_addr = 25'h00200; cas_req = 1;
    run(10);
    checks++;
    if (obs_val - v0 !== 1 || cas_data !== 8'h3C) begin
      failures++;
      $display("FAIL read: valids=%0d data=%h want 1 3c",
               obs_val - v0, cas_data);
    end
  endtask

  task automatic test_reset_mid();
    mode = 0; lat_fix = 999;
    cas_addr = 25'h00005; cas_req = 1;
    run(4);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_rd !== 0 || busy !== 0 || cas_valid !== 0
        || cas_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid: rd=%b busy=%b valid=%b data=%h",
               mem_rd, busy, cas_valid, cas_data);
    end
    model_reset();
    @(posedge clk_sys); #3;
    reset = 1'b0;
    mem_ready = 1; mem_dout = 8'h77;
    run(6);
  endtask

  task automatic test_arbitration();
    bit want[4];
    bit ok;
    do_reset();
    gseq.delete();
    mode = 1; lat_fix = 1;
    dl_addr = 25'h00020; dl_data = 8'h11; dl_req = 1;
    cas_addr = 25'h00020; cas_req = 1;
    for (int i = 0; i < 40 && gseq.size() < 4; i++) cycle();
    dl_req = 0; cas_req = 0; mode = 0;
    run(4);
    for (int i = 0; i < 4; i++) want[i] = RR && (i % 2 == 1);
    ok = gseq.size() >= 4;
    for (int i = 0; i < 4 && ok; i++) ok = (gseq[i] == want[i]);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL arb_order: got %p want %p", gseq, want);
    end
  endtask

  task automatic test_timeout();
    int d0;
    do_reset();
    mode = 0; lat_fix = 999;
    cas_addr = 25'h00007; cas_req = 1;
    run(TIMEOUT + 6);
    checks++;
    if (tmo_err !== 1 || cas_data !== 8'hFF) begin
      failures++;
      $display("FAIL timeout: tmo=%b data=%h want 1 ff",
               tmo_err, cas_data);
    end
    d0 = obs_dl;
    lat_fix = 1;
    dl_addr = 25'h00008; dl_data = 8'h5A; dl_req = 1;
    run(5);
    checks++;
    if (obs_dl - d0 !== 1 || mem_din !== 8'h5A) begin
      failures++;
      $display("FAIL after_timeout: acks=%0d din=%h want 1 5a",
               obs_dl - d0, mem_din);
    end
  endtask

  task automatic test_random();
    do_reset();
    mode = 2; lat_fix = -1;
    run(3000);
    mode = 0; dl_req = 0; cas_req = 0;
    run(TIMEOUT + 8);
  endtask

  initial begin
    obs_dl = 0; obs_val = 0;
    mode = 0; lat_fix = 1;
    test_reset();
    test_write();
    test_read();
    test_reset_mid();
    test_arbitration();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
